// File: rtl/pe_pkg.sv
// Shared definitions for the MAC processing element.
// Holds the default geometry constants, the width helpers that derive sum
// widths from a product width and a term count, the 8-bit requant clip and
// the saturating add used by the accumulator.
package pe_pkg;

    localparam int DEF_LANES   = 72;
    localparam int DEF_GROUP   = 9;
    localparam int DEF_DW      = 8;
    localparam int DEF_ACC_W   = 32;
    localparam int DEF_SHIFT   = 10;
    localparam int DEF_OUT_MAX = 127;

    // All helper arithmetic runs at this width; callers sign-extend into it
    // and truncate back to their own width afterwards.
    localparam int WIDE_W = 64;
    typedef logic signed [WIDE_W-1:0] wide_t;

    // Width needed to add n signed terms of pw bits without overflow.
    function automatic int sum_w(input int pw, input int n);
        return pw + $clog2(n);
    endfunction

    // Negative -> 0; otherwise arithmetic shift, then clamp to out_max.
    // The whole shifted value is compared, so large magnitudes cannot alias
    // into a small byte.
    function automatic logic [7:0] clip8(input wide_t v, input int shift, input int out_max);
        wide_t q;
        wide_t lim;
        lim = wide_t'(out_max);
        if (v < 0) begin
            return 8'd0;
        end
        q = v >>> shift;
        if (q > lim) begin
            return lim[7:0];
        end
        return q[7:0];
    endfunction

    // a + b clamped to the signed range of an acc_w-bit register.
    function automatic wide_t sat_val(input wide_t a, input wide_t b, input int acc_w);
        wide_t s;
        wide_t mx;
        wide_t mn;
        s  = a + b;
        mx = (wide_t'(1) <<< (acc_w - 1)) - wide_t'(1);
        mn = -mx - wide_t'(1);
        if (s > mx) begin
            return mx;
        end
        if (s < mn) begin
            return mn;
        end
        return s;
    endfunction

    // True when sat_val would clamp.
    function automatic logic sat_hit(input wide_t a, input wide_t b, input int acc_w);
        return sat_val(a, b, acc_w) != (a + b);
    endfunction

endpackage

// File: rtl/mac_pe_acc_if.sv
// Beat/result bundle of the MAC PE.
// master: beat source (in_valid/in_first/in_last/act/wgt) and result sink.
// slave : the PE itself; drives grp_* and acc_* results.
interface mac_pe_acc_if #(
    parameter int LANES = 72,
    parameter int DW    = 8,
    parameter int NGRP  = 8,
    parameter int ACC_W = 32
);
    logic                   in_valid;
    logic                   in_first;
    logic                   in_last;
    logic [LANES*DW-1:0]    act;
    logic [LANES*DW-1:0]    wgt;
    logic                   grp_valid;
    logic [NGRP*8-1:0]      grp_out;
    logic                   acc_valid;
    logic [ACC_W-1:0]       acc_out;
    logic [7:0]             acc_clip;
    logic [15:0]            acc_beats;
    logic                   acc_ovf;

    modport master (
        output in_valid, in_first, in_last, act, wgt,
        input  grp_valid, grp_out, acc_valid, acc_out, acc_clip, acc_beats, acc_ovf
    );

    modport slave (
        input  in_valid, in_first, in_last, act, wgt,
        output grp_valid, grp_out, acc_valid, acc_out, acc_clip, acc_beats, acc_ovf
    );
endinterface

// File: rtl/pe_group_tree.sv
// Registered sum of GROUP signed products (one conv output group).
// Ports: clk, rst_n (async active-low), en (load enable = stage valid),
// prods (GROUP packed PW-bit signed products), sum (registered SW-bit sum).
module pe_group_tree
    import pe_pkg::*;
#(
    parameter int GROUP = DEF_GROUP,
    parameter int PW    = 2 * DEF_DW,
    parameter int SW    = sum_w(PW, GROUP)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [GROUP*PW-1:0]     prods,
    output logic signed [SW-1:0]    sum
);
    logic signed [SW-1:0] sum_next;

    always_comb begin
        sum_next = '0;
        for (int i = 0; i < GROUP; i++) begin
            sum_next = sum_next + SW'($signed(prods[i*PW +: PW]));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum <= '0;
        end else if (en) begin
            sum <= sum_next;
        end
    end
endmodule

// File: rtl/mac_pe_acc.sv
// Multi-lane int MAC PE with per-group sums and multi-beat accumulation.
// Pipeline: S0 input regs, S1 products, S2 group sums, S3 beat total and
// accumulator update, S4 clipped outputs; 5-cycle latency, one beat/cycle.
// Ports: clk, rst_n (async active-low), bus (mac_pe_acc_if.slave):
// beats in via in_valid/in_first/in_last/act/wgt, per-beat group results on
// grp_valid/grp_out, accumulation results on acc_valid/acc_out/acc_clip/
// acc_beats/acc_ovf.
module mac_pe_acc
    import pe_pkg::*;
#(
    parameter int LANES   = DEF_LANES,
    parameter int GROUP   = DEF_GROUP,
    parameter int DW      = DEF_DW,
    parameter int ACC_W   = DEF_ACC_W,
    parameter int SHIFT   = DEF_SHIFT,
    parameter int OUT_MAX = DEF_OUT_MAX
) (
    input  logic        clk,
    input  logic        rst_n,
    mac_pe_acc_if.slave bus
);
    localparam int NGRP = LANES / GROUP;
    localparam int PW   = 2 * DW;
    localparam int GW   = sum_w(PW, GROUP);
    localparam int TW   = sum_w(PW, LANES);

    // ---------------- S0: inputs ----------------
    logic                v0_reg, first0_reg, last0_reg;
    logic [LANES*DW-1:0] act0_reg, wgt0_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v0_reg     <= 1'b0;
            first0_reg <= 1'b0;
            last0_reg  <= 1'b0;
            act0_reg   <= '0;
            wgt0_reg   <= '0;
        end else begin
            v0_reg     <= bus.in_valid;
            first0_reg <= bus.in_valid & bus.in_first;
            last0_reg  <= bus.in_valid & bus.in_last;
            if (bus.in_valid) begin
                act0_reg <= bus.act;
                wgt0_reg <= bus.wgt;
            end
        end
    end

    // ---------------- S1: products ----------------
    logic                v1_reg, first1_reg, last1_reg;
    logic [LANES*PW-1:0] prod1_flat;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic signed [PW-1:0] prod_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    prod_reg <= '0;
                end else if (v0_reg) begin
                    prod_reg <= PW'($signed(act0_reg[gi*DW +: DW])) *
                                PW'($signed(wgt0_reg[gi*DW +: DW]));
                end
            end
            assign prod1_flat[gi*PW +: PW] = prod_reg;
        end
    endgenerate

    // ---------------- S2: group sums ----------------
    logic               v2_reg, first2_reg, last2_reg;
    logic [NGRP*GW-1:0] gsum2_flat;

    generate
        for (genvar gi = 0; gi < NGRP; gi++) begin : g_grp
            pe_group_tree #(
                .GROUP (GROUP),
                .PW    (PW),
                .SW    (GW)
            ) u_tree (
                .clk   (clk),
                .rst_n (rst_n),
                .en    (v1_reg),
                .prods (prod1_flat[gi*GROUP*PW +: GROUP*PW]),
                .sum   (gsum2_flat[gi*GW +: GW])
            );
        end
    endgenerate

    // Beat-level control rides alongside the data through S1 and S2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_reg     <= 1'b0;
            first1_reg <= 1'b0;
            last1_reg  <= 1'b0;
            v2_reg     <= 1'b0;
            first2_reg <= 1'b0;
            last2_reg  <= 1'b0;
        end else begin
            v1_reg     <= v0_reg;
            first1_reg <= first0_reg;
            last1_reg  <= last0_reg;
            v2_reg     <= v1_reg;
            first2_reg <= first1_reg;
            last2_reg  <= last1_reg;
        end
    end

    // ---------------- S3: beat total + accumulator ----------------
    logic signed [TW-1:0]    beat_total;
    logic signed [ACC_W-1:0] res_acc;
    logic [15:0]             res_beats;
    logic                    res_ovf;
    wide_t                   base_w, total_w;

    always_comb begin
        beat_total = '0;
        for (int g = 0; g < NGRP; g++) begin
            beat_total = beat_total + TW'($signed(gsum2_flat[g*GW +: GW]));
        end
    end

    logic                    v3_reg, last3_reg;
    logic [NGRP*GW-1:0]      gsum3_reg;
    logic signed [ACC_W-1:0] acc3_reg;
    logic [15:0]             beats3_reg;
    logic                    ovf3_reg;
    // Open accumulation; zeroed after every last beat so that a stray
    // non-first beat starts from 0 with a beat count of 1.
    logic signed [ACC_W-1:0] acc_reg;
    logic [15:0]             beats_reg;
    logic                    ovf_reg;

    always_comb begin
        base_w    = first2_reg ? '0 : wide_t'(acc_reg);
        total_w   = wide_t'(beat_total);
        res_acc   = ACC_W'(sat_val(base_w, total_w, ACC_W));
        res_ovf   = first2_reg ? 1'b0 : (ovf_reg | sat_hit(base_w, total_w, ACC_W));
        res_beats = first2_reg ? 16'd1 :
                    ((beats_reg == 16'hFFFF) ? 16'hFFFF : beats_reg + 16'd1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3_reg     <= 1'b0;
            last3_reg  <= 1'b0;
            gsum3_reg  <= '0;
            acc3_reg   <= '0;
            beats3_reg <= '0;
            ovf3_reg   <= 1'b0;
            acc_reg    <= '0;
            beats_reg  <= '0;
            ovf_reg    <= 1'b0;
        end else begin
            v3_reg    <= v2_reg;
            last3_reg <= last2_reg;
            if (v2_reg) begin
                gsum3_reg  <= gsum2_flat;
                acc3_reg   <= res_acc;
                beats3_reg <= res_beats;
                ovf3_reg   <= res_ovf;
                acc_reg    <= last2_reg ? '0    : res_acc;
                beats_reg  <= last2_reg ? 16'd0 : res_beats;
                ovf_reg    <= last2_reg ? 1'b0  : res_ovf;
            end
        end
    end

    // ---------------- S4: clipped outputs ----------------
    logic [NGRP*8-1:0] grp_clip;

    generate
        for (genvar gi = 0; gi < NGRP; gi++) begin : g_clip
            assign grp_clip[gi*8 +: 8] =
                clip8(wide_t'($signed(gsum3_reg[gi*GW +: GW])), SHIFT, OUT_MAX);
        end
    endgenerate

    logic              grp_valid_reg, acc_valid_reg, acc_ovf_reg;
    logic [NGRP*8-1:0] grp_out_reg;
    logic [ACC_W-1:0]  acc_out_reg;
    logic [7:0]        acc_clip_reg;
    logic [15:0]       acc_beats_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grp_valid_reg <= 1'b0;
            acc_valid_reg <= 1'b0;
            grp_out_reg   <= '0;
            acc_out_reg   <= '0;
            acc_clip_reg  <= '0;
            acc_beats_reg <= '0;
            acc_ovf_reg   <= 1'b0;
        end else begin
            grp_valid_reg <= v3_reg;
            acc_valid_reg <= v3_reg & last3_reg;
            if (v3_reg) begin
                grp_out_reg <= grp_clip;
            end
            if (v3_reg && last3_reg) begin
                acc_out_reg   <= acc3_reg;
                acc_clip_reg  <= clip8(wide_t'(acc3_reg), SHIFT, OUT_MAX);
                acc_beats_reg <= beats3_reg;
                acc_ovf_reg   <= ovf3_reg;
            end
        end
    end

    assign bus.grp_valid = grp_valid_reg;
    assign bus.grp_out   = grp_out_reg;
    assign bus.acc_valid = acc_valid_reg;
    assign bus.acc_out   = acc_out_reg;
    assign bus.acc_clip  = acc_clip_reg;
    assign bus.acc_beats = acc_beats_reg;
    assign bus.acc_ovf   = acc_ovf_reg;
endmodule

// File: tb/tb_mac_pe_acc.sv
// Bench for mac_pe_acc: directed and random beats driven into a default
// instance (ACC_W=32) and a narrow-accumulator instance (ACC_W=22); a
// per-cycle table of expected results is filled from an arithmetic model
// five cycles ahead and compared on every falling edge.
module tb_mac_pe_acc;
    localparam int LANES   = 72;
    localparam int GROUP   = 9;
    localparam int NGRP    = 8;
    localparam int SHIFT   = 10;
    localparam int OUT_MAX = 127;
    localparam int NSLOT   = 1024;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mac_pe_acc_if #(.LANES(LANES), .DW(8), .NGRP(NGRP), .ACC_W(32)) mif ();
    mac_pe_acc_if #(.LANES(LANES), .DW(8), .NGRP(NGRP), .ACC_W(22)) sif ();

    mac_pe_acc dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (mif)
    );

    mac_pe_acc #(.ACC_W(22)) dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sif)
    );

    typedef struct packed {
        logic        gv;
        logic [63:0] grp;
        logic        av;
        logic [31:0] acc32;
        logic [7:0]  clip32;
        logic [15:0] beats;
        logic        ovf32;
        logic [21:0] acc22;
        logic [7:0]  clip22;
        logic        ovf22;
    } exp_t;

    exp_t exp_tab [NSLOT];

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    bit mon_on = 1'b0;

    longint m_acc32, m_acc22;
    int     m_beats;
    bit     m_ovf32, m_ovf22;

    logic [LANES*8-1:0] act_v, wgt_v;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // Requant: negatives clip to 0, otherwise divide by 2^SHIFT and cap.
    function automatic logic [7:0] ref_clip(input longint v);
        longint q;
        if (v < 0) return 8'd0;
        q = v / (longint'(1) << SHIFT);
        if (q > OUT_MAX) return 8'(OUT_MAX);
        return 8'(q);
    endfunction

    function automatic longint sat_w(input longint v, input int w);
        longint mx;
        mx = (longint'(1) << (w - 1)) - 1;
        if (v > mx) return mx;
        if (v < -mx - 1) return -mx - 1;
        return v;
    endfunction

    task automatic model_clear();
        m_acc32 = 0;
        m_acc22 = 0;
        m_beats = 0;
        m_ovf32 = 1'b0;
        m_ovf22 = 1'b0;
    endtask

    task automatic model_beat(input bit f, input bit l);
        exp_t   e;
        longint gs, tot, s;
        e = '0;
        e.gv = 1'b1;
        tot = 0;
        for (int g = 0; g < NGRP; g++) begin
            gs = 0;
            for (int j = 0; j < GROUP; j++) begin
                gs += longint'($signed(act_v[(g*GROUP+j)*8 +: 8])) *
                      longint'($signed(wgt_v[(g*GROUP+j)*8 +: 8]));
            end
            e.grp[g*8 +: 8] = ref_clip(gs);
            tot += gs;
        end
        if (f) begin
            m_acc32 = tot;
            m_acc22 = tot;
            m_beats = 1;
            m_ovf32 = 1'b0;
            m_ovf22 = 1'b0;
        end else begin
            s = m_acc32 + tot;
            if (sat_w(s, 32) != s) m_ovf32 = 1'b1;
            m_acc32 = sat_w(s, 32);
            s = m_acc22 + tot;
            if (sat_w(s, 22) != s) m_ovf22 = 1'b1;
            m_acc22 = sat_w(s, 22);
            m_beats = (m_beats < 65535) ? m_beats + 1 : 65535;
        end
        if (l) begin
            e.av     = 1'b1;
            e.acc32  = 32'(m_acc32);
            e.clip32 = ref_clip(m_acc32);
            e.beats  = 16'(m_beats);
            e.ovf32  = m_ovf32;
            e.acc22  = 22'(m_acc22);
            e.clip22 = ref_clip(m_acc22);
            e.ovf22  = m_ovf22;
            model_clear();
        end
        exp_tab[(cyc + 5) % NSLOT] = e;
    endtask

    task automatic drive(input bit v, input bit f, input bit l);
        @(negedge clk);
        mif.in_valid = v; mif.in_first = f; mif.in_last = l;
        sif.in_valid = v; sif.in_first = f; sif.in_last = l;
        mif.act = act_v; mif.wgt = wgt_v;
        sif.act = act_v; sif.wgt = wgt_v;
        if (v) model_beat(f, l);
        else   exp_tab[(cyc + 5) % NSLOT] = '0;
    endtask

    task automatic fill(input int a, input int w);
        for (int i = 0; i < LANES; i++) begin
            act_v[i*8 +: 8] = 8'(a);
            wgt_v[i*8 +: 8] = 8'(w);
        end
    endtask

    task automatic fill_rand();
        for (int i = 0; i < LANES; i++) begin
            act_v[i*8 +: 8] = 8'($urandom);
            wgt_v[i*8 +: 8] = 8'($urandom);
        end
    endtask

    // One cycle of reset between falling edges; in-flight beats are dropped.
    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        for (int k = 1; k <= 10; k++) exp_tab[(cyc + k) % NSLOT] = '0;
        model_clear();
        @(negedge clk);
        exp_tab[(cyc + 5) % NSLOT] = '0;
        #2;
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (mon_on) begin
            e = exp_tab[cyc % NSLOT];
            chk("grp_valid", 64'(mif.grp_valid), 64'(e.gv));
            if (e.gv) chk("grp_out", mif.grp_out, e.grp);
            chk("acc_valid", 64'(mif.acc_valid), 64'(e.av));
            chk("sat_acc_valid", 64'(sif.acc_valid), 64'(e.av));
            if (e.av) begin
                chk("acc_out",       64'(mif.acc_out),   64'(e.acc32));
                chk("acc_clip",      64'(mif.acc_clip),  64'(e.clip32));
                chk("acc_beats",     64'(mif.acc_beats), 64'(e.beats));
                chk("acc_ovf",       64'(mif.acc_ovf),   64'(e.ovf32));
                chk("sat_acc_out",   64'(sif.acc_out),   64'(e.acc22));
                chk("sat_acc_clip",  64'(sif.acc_clip),  64'(e.clip22));
                chk("sat_acc_beats", 64'(sif.acc_beats), 64'(e.beats));
                chk("sat_acc_ovf",   64'(sif.acc_ovf),   64'(e.ovf22));
                $display("txn @%0d: acc_out=%0d clip=%0d beats=%0d ovf=%0d | acc22=%0d ovf22=%0d",
                         cyc, $signed(mif.acc_out), mif.acc_clip, mif.acc_beats, mif.acc_ovf,
                         $signed(sif.acc_out), sif.acc_ovf);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < NSLOT; i++) exp_tab[i] = '0;
        model_clear();
        fill(0, 0);
        mif.in_valid = 1'b0; mif.in_first = 1'b0; mif.in_last = 1'b0;
        sif.in_valid = 1'b0; sif.in_first = 1'b0; sif.in_last = 1'b0;
        mif.act = act_v; mif.wgt = wgt_v;
        sif.act = act_v; sif.wgt = wgt_v;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_grp_valid", 64'(mif.grp_valid), 64'd0);
        chk("rst_grp_out",   mif.grp_out,         64'd0);
        chk("rst_acc_valid", 64'(mif.acc_valid), 64'd0);
        chk("rst_acc_out",   64'(mif.acc_out),   64'd0);
        chk("rst_acc_clip",  64'(mif.acc_clip),  64'd0);
        chk("rst_acc_beats", 64'(mif.acc_beats), 64'd0);
        chk("rst_acc_ovf",   64'(mif.acc_ovf),   64'd0);
        chk("rst_sat_valid", 64'(sif.acc_valid), 64'd0);
        #2;
        rst_n = 1'b1;
        mon_on = 1'b1;

        // Single beats: small positive, clipped large, negative.
        fill(16, 8);    drive(1'b1, 1'b1, 1'b1);
        fill(127, 127); drive(1'b1, 1'b1, 1'b1);
        fill(16, -8);   drive(1'b1, 1'b1, 1'b1);
        repeat (3) drive(1'b0, 1'b0, 1'b0);

        // Three-beat accumulation.
        fill(16, 8);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1);

        // Back-to-back alternating single beats.
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) fill(16, 8);
            else            fill(127, 127);
            drive(1'b1, 1'b1, 1'b1);
        end

        // Reset in the middle of a run, then a fresh single beat.
        fill(16, 8);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        do_reset();
        fill(16, 8);
        drive(1'b1, 1'b1, 1'b1);

        // Restart without last, then a non-first beat with nothing open.
        fill(16, 8);
        drive(1'b1, 1'b1, 1'b0);
        fill(127, 127);
        drive(1'b1, 1'b1, 1'b1);
        fill(16, -8);
        drive(1'b1, 1'b0, 1'b1);

        // Flags on idle cycles must be ignored.
        drive(1'b0, 1'b1, 1'b1);

        // Eight max beats: saturates the narrow accumulator positively.
        fill(127, 127);
        drive(1'b1, 1'b1, 1'b0);
        repeat (6) drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1);

        // And negatively.
        fill(-128, 127);
        drive(1'b1, 1'b1, 1'b0);
        repeat (6) drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1);

        // Random traffic.
        for (int k = 0; k < 600; k++) begin
            case ($urandom_range(0, 3))
                0, 1:    fill_rand();
                2:       fill(127, 127);
                default: fill(-128, 127);
            endcase
            drive($urandom_range(0, 9) < 8, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
        end

        repeat (10) drive(1'b0, 1'b0, 1'b0);
        mon_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
